// File: rtl/dilithium_pkg.sv
// Shared constants, state encoding and the eta=4 nibble decoder used by the
// secret-key polynomial unpacker.
package dilithium_pkg;

  localparam int N          = 256;
  localparam int ETA        = 4;
  localparam int COEF_W     = 32;
  localparam int POLY_IDX_W = 4;
  localparam int COEF_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Coefficient is stored as ETA - nib; nibbles above 2*ETA are malformed but
  // still decoded so the downstream path sees a deterministic value.
  function automatic logic [COEF_W-1:0] eta_decode(input logic [3:0] nib);
    return COEF_W'(ETA) - {{(COEF_W-4){1'b0}}, nib};
  endfunction

endpackage

// File: rtl/polyeta_unpack_pair.sv
// Combinational decode of one packed byte into its two signed coefficients
// plus a flag that either nibble lies outside 0..8.
module polyeta_unpack_pair
  import dilithium_pkg::*;
(
  input  logic [7:0]        pair_byte,
  output logic [COEF_W-1:0] coef0,
  output logic [COEF_W-1:0] coef1,
  output logic              bad
);

  logic [1:0][COEF_W-1:0] coef_w;
  logic [1:0]             nib_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign coef_w[gi]  = eta_decode(pair_byte[4*gi +: 4]);
      assign nib_bad[gi] = (pair_byte[4*gi +: 4] > 4'd8);
    end
  endgenerate

  assign coef0 = coef_w[0];
  assign coef1 = coef_w[1];
  assign bad   = |nib_bad;

endmodule

// File: rtl/polyeta_unpack_ctrl.sv
// Streaming sequencer: takes 32-bit eta-packed words and emits one signed
// coefficient pair per handshake, tracking polynomial/coefficient indices.
module polyeta_unpack_ctrl
  import dilithium_pkg::*;
#(
  parameter int NUM_POLY = 11
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [COEF_W-1:0]     out_coef0,
  output logic [COEF_W-1:0]     out_coef1,
  output logic [POLY_IDX_W-1:0] out_poly_idx,
  output logic [COEF_IDX_W-1:0] out_coef_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [POLY_IDX_W-1:0] LAST_POLY = POLY_IDX_W'(NUM_POLY - 1);
  localparam logic [COEF_IDX_W-1:0] LAST_COEF = COEF_IDX_W'(N - 2);

  state_t                  state_reg, state_next;
  logic [31:0]             word_reg, word_next;
  logic [1:0]              byte_sel_reg, byte_sel_next;
  logic [COEF_IDX_W-1:0]   coef_cnt_reg, coef_cnt_next;
  logic [POLY_IDX_W-1:0]   poly_cnt_reg, poly_cnt_next;
  logic                    err_reg, err_next;

  logic [7:0]              cur_byte;
  logic [COEF_W-1:0]       pair_coef0, pair_coef1;
  logic                    pair_bad;
  logic                    last_pair;
  logic                    emit_active;

  assign cur_byte    = word_reg[{byte_sel_reg, 3'b000} +: 8];
  assign last_pair   = (poly_cnt_reg == LAST_POLY) && (coef_cnt_reg == LAST_COEF);
  assign emit_active = (state_reg == ST_EMIT);

  polyeta_unpack_pair u_pair (
    .pair_byte (cur_byte),
    .coef0     (pair_coef0),
    .coef1     (pair_coef1),
    .bad       (pair_bad)
  );

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    byte_sel_next = byte_sel_reg;
    coef_cnt_next = coef_cnt_reg;
    poly_cnt_next = poly_cnt_reg;
    err_next      = err_reg;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_LOAD;
          coef_cnt_next = '0;
          poly_cnt_next = '0;
          err_next      = 1'b0;
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_next     = in_data;
          byte_sel_next = 2'd0;
          state_next    = ST_EMIT;
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        // Refill on the last byte of a word so the stream has no bubble.
        if (byte_sel_reg == 2'd3 && !last_pair) begin
          in_ready = out_ready;
        end
        if (out_ready) begin
          err_next = err_reg | pair_bad;
          if (last_pair) begin
            state_next = ST_DONE;
          end else begin
            if (coef_cnt_reg == LAST_COEF) begin
              coef_cnt_next = '0;
              poly_cnt_next = poly_cnt_reg + 1'b1;
            end else begin
              coef_cnt_next = coef_cnt_reg + COEF_IDX_W'(2);
            end
            if (byte_sel_reg != 2'd3) begin
              byte_sel_next = byte_sel_reg + 1'b1;
            end else if (in_valid) begin
              word_next     = in_data;
              byte_sel_next = 2'd0;
            end else begin
              state_next = ST_LOAD;
            end
          end
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      word_reg     <= '0;
      byte_sel_reg <= '0;
      coef_cnt_reg <= '0;
      poly_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      byte_sel_reg <= byte_sel_next;
      coef_cnt_reg <= coef_cnt_next;
      poly_cnt_reg <= poly_cnt_next;
      err_reg      <= err_next;
    end
  end

  // Coefficients are forced to zero outside EMIT so idle outputs read clean.
  assign out_coef0    = emit_active ? pair_coef0 : '0;
  assign out_coef1    = emit_active ? pair_coef1 : '0;
  assign out_poly_idx = poly_cnt_reg;
  assign out_coef_idx = coef_cnt_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign err          = err_reg;

endmodule

// File: tb/tb_polyeta_unpack_ctrl.sv
// Self-checking bench: table vectors for known words, a queue scoreboard for
// full random jobs, stalls, mid-job reset and start-ignored corner cases.
module tb_polyeta_unpack_ctrl;

  localparam int NP    = 11;
  localparam int WORDS = NP * 32;
  localparam int PAIRS = NP * 128;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_coef0, out_coef1;
  logic [3:0]  out_poly_idx;
  logic [7:0]  out_coef_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, err;

  polyeta_unpack_ctrl #(.NUM_POLY(NP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_coef0    (out_coef0),
    .out_coef1    (out_coef1),
    .out_poly_idx (out_poly_idx),
    .out_coef_idx (out_coef_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // exp holds eight signed bytes: {c1_b3,c0_b3,...,c1_b0,c0_b0}
  typedef struct packed {
    logic [31:0] word;
    logic [63:0] exp;
    logic        err_after;
  } vec_t;

  typedef struct packed {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [3:0]  poly;
    logic [7:0]  idx;
  } pair_t;

  vec_t  vecs [5];
  pair_t exp_q [$];
  pair_t held;
  int    checks = 0, errors = 0, cycle = 0;
  int    exp_poly, exp_coef;
  int    pops, done_cnt, first_accept, first_valid, first_pop, last_pop, done_cyc;
  bit    prev_stall, accepted;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d", name, cycle);
  endtask

  task automatic push_pair(input int c0, input int c1);
    pair_t p;
    p.c0   = 32'(c0);
    p.c1   = 32'(c1);
    p.poly = 4'(exp_poly);
    p.idx  = 8'(exp_coef);
    exp_q.push_back(p);
    exp_coef += 2;
    if (exp_coef == 256) begin
      exp_coef = 0;
      exp_poly++;
    end
  endtask

  task automatic push_model(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      push_pair(4 - int'(w[8*b +: 4]), 4 - int'(w[8*b+4 +: 4]));
    end
  endtask

  task automatic push_table(input int i);
    logic [63:0]       e;
    logic signed [7:0] lo, hi;
    e = vecs[i].exp;
    for (int b = 0; b < 4; b++) begin
      lo = e[16*b +: 8];
      hi = e[16*b+8 +: 8];
      push_pair(int'(lo), int'(hi));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int n = 0; n < 8; n++) w[4*n +: 4] = 4'($urandom_range(0, 8));
    return w;
  endfunction

  // One clock: inputs already driven at the negedge; sample at negedge+1.
  task automatic step();
    pair_t cur, e;
    #1;
    cur = '{out_coef0, out_coef1, out_poly_idx, out_coef_idx};
    if (prev_stall) begin
      chk("hold_valid", 96'(out_valid), 96'(1));
      chk("hold_pair", 96'(cur), 96'(held));
    end
    accepted = in_valid && in_ready;
    if (accepted && first_accept < 0) first_accept = cycle;
    if (out_valid && first_valid < 0) first_valid = cycle;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("pair_unexpected");
      end else begin
        e = exp_q.pop_front();
        chk("pair", 96'(cur), 96'(e));
        $display("pair poly=%0d idx=%0d c0=%0d c1=%0d", cur.poly, cur.idx,
                 $signed(cur.c0), $signed(cur.c1));
      end
      pops++;
      if (first_pop < 0) first_pop = cycle;
      last_pop = cycle;
    end
    prev_stall = out_valid && !out_ready;
    if (prev_stall) begin
      held = cur;
      chk("stall_in_ready", 96'(in_ready), 96'(0));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic run_job(input bit stalls, input int n_table, input int abort_poly,
                         input bit hold_start);
    int          sent = 0, budget = 0, tchk = 0, tgt;
    bit          have = 0, from_tbl = 0;
    logic [31:0] w = 32'd0;
    exp_q.delete();
    exp_poly = 0; exp_coef = 0; pops = 0; done_cnt = 0;
    first_accept = -1; first_valid = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
    prev_stall = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("err_cleared_on_start", 96'(err), 96'(0));
    chk("busy_after_start", 96'(busy), 96'(1));
    if (!hold_start) start = 1'b0;
    while (done_cnt == 0 && budget < BUDGET) begin
      budget++;
      if (tchk < sent && tchk < n_table && exp_q.size() == 0) begin
        chk("err_after_vec", 96'(err), 96'(vecs[tchk].err_after));
        tchk++;
      end
      tgt = (sent < n_table) ? sent : n_table;
      if (!have && sent < WORDS && tchk == tgt) begin
        from_tbl = (sent < n_table);
        w = from_tbl ? vecs[sent].word : rand_word();
        have = 1;
      end
      in_data   = w;
      in_valid  = (have && (!stalls || $urandom_range(0, 3) != 0)) || (sent == WORDS);
      out_ready = !stalls || ($urandom_range(0, 2) != 0);
      if (abort_poly >= 0 && out_valid && int'(out_poly_idx) == abort_poly &&
          out_coef_idx >= 8'd100) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        prev_stall = 0;
        #1;
        chk("abort_outputs", 96'({in_ready, out_valid, busy, done, err, out_coef0, out_coef1,
                                  out_poly_idx, out_coef_idx}), 96'(0));
        done_cnt = 0;
        repeat (5) step();
        chk("abort_no_done", 96'(done_cnt), 96'(0));
        exp_q.delete();
        return;
      end
      step();
      if (accepted) begin
        if (sent >= WORDS) begin
          fail_now("extra_word_accepted");
        end else begin
          if (from_tbl) push_table(sent);
          else push_model(w);
          sent++;
          have = 0;
        end
      end
    end
    if (budget >= BUDGET) fail_now("job_timeout");
    start = 1'b0; in_valid = 1'b0;
    chk("pairs_total", 96'(pops), 96'(PAIRS));
    chk("done_after_last_pair", 96'(done_cyc), 96'(last_pop + 1));
    chk("first_pair_latency", 96'(first_valid), 96'(first_accept + 1));
    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    if (!stalls) chk("no_bubbles", 96'(last_pop - first_pop), 96'(PAIRS - 1));
    step();
    chk("idle_after_done", 96'({busy, done, out_valid}), 96'(0));
    chk("single_done", 96'(done_cnt), 96'(1));
  endtask

  initial begin
    vecs[0] = '{32'h8765_4310, 64'hFCFD_FEFF_0001_0304, 1'b0};
    vecs[1] = '{32'h0000_0000, 64'h0404_0404_0404_0404, 1'b0};
    vecs[2] = '{32'h8888_8888, 64'hFCFC_FCFC_FCFC_FCFC, 1'b0};
    vecs[3] = '{32'h0000_9A00, 64'h0404_0404_FBFA_0404, 1'b1};
    vecs[4] = '{32'h0102_0304, 64'h0403_0402_0401_0400, 1'b1};

    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 96'({in_ready, out_valid, busy, done, err, out_coef0, out_coef1,
                            out_poly_idx, out_coef_idx}), 96'(0));
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // Table words first, random stalls/gaps, start held high the whole job.
    run_job(1'b1, 5, -1, 1'b1);
    chk("err_sticky_idle", 96'(err), 96'(1));
    // Always-ready full job; accepted start clears err.
    run_job(1'b0, 0, -1, 1'b0);
    chk("err_clean_job", 96'(err), 96'(0));
    // Reset in the middle of poly 3, then a fresh clean job.
    run_job(1'b0, 0, 3, 1'b0);
    run_job(1'b0, 0, -1, 1'b0);
    chk("err_after_restart", 96'(err), 96'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
